race_sequencer: RTL and testbench
=================================

// Module: race_sequencer
// PURPOSE
//  Top-level game-flow controller. Sequences a race: reload cars to their init pose,
//  run a 3-2-1 countdown, enable car physics, count laps per car, declare the winner
//  and hold the result. Sits between the input/physics blocks and the bar renderer.
//  Lap/countdown outputs drive OBJECT_BAR_DIGIT.
// PARAMETERS
//  LAP_MAX            3     laps to win (game_pkg::LAP_MAX)
//  FRAMES_PER_SEC     60    frame ticks per countdown step
//  COUNTDOWN_SEC      3     countdown start value
//  FINISH_HOLD_FRAMES 300   frames the result is held before auto-return to IDLE
//  POS_WIDTH          12    signed car coordinate width
//  FINISH_LINE_X      -538  finish line x (world coords)
//  CHECKPOINT_X       500   x a car must reach (>=) to arm its next lap count
// PORTS
//  i_clk          in   1          system clock
//  i_rst          in   1          asynchronous reset, active-high
//  i_frame_tick   in   1          1-cycle pulse per video frame; all sequencing advances on it
//  i_start        in   1          level/pulse start request from player input
//  i_car1_x       in   POS_WIDTH  signed car1 centre x
//  i_car1_y       in   POS_WIDTH  signed car1 centre y
//  i_car2_x       in   POS_WIDTH  signed car2 centre x
//  i_car2_y       in   POS_WIDTH  signed car2 centre y
//  o_state        out  3          RaceState (IDLE/INIT/COUNTDOWN/RACE/FINISH)
//  o_load_init    out  1          1-cycle pulse: physics loads CARn_INIT_X/Y, CAR_INIT_ANGLE, v=0
//  o_physics_en   out  1          high only in RACE
//  o_countdown    out  SINGLE_DIGIT_WIDTH  digit shown during COUNTDOWN (3,2,1), else 0
//  o_car1_lap     out  SINGLE_DIGIT_WIDTH  completed laps car1, saturates at LAP_MAX
//  o_car2_lap     out  SINGLE_DIGIT_WIDTH  completed laps car2
//  o_winner       out  2          0 none, 1 car1, 2 car2, 3 tie; valid in FINISH
// BEHAVIOUR
//  Reset (any state, any cycle): state=IDLE, all counters/laps/winner=0, o_load_init=0,
//   o_physics_en=0, o_countdown=0, checkpoint flags cleared, prev-x regs cleared.
//  Only i_frame_tick cycles advance state/counters; between ticks all regs hold.
//  IDLE: on tick with i_start=1 -> INIT.
//  INIT: o_load_init asserted for exactly the first cycle of INIT (registered, 1 cycle
//   after transition); laps, winner, flags cleared; next tick -> COUNTDOWN.
//  COUNTDOWN: o_countdown starts at COUNTDOWN_SEC, decrements every FRAMES_PER_SEC
//   ticks; after the tick that would take it to 0 -> RACE (o_countdown=0).
//   Total COUNTDOWN dwell = COUNTDOWN_SEC*FRAMES_PER_SEC ticks. i_start ignored.
//  RACE: o_physics_en=1. Per car, per tick, with prev_x = x sampled last tick:
//   - x >= CHECKPOINT_X -> set armed flag.
//   - crossing: prev_x >= FINISH_LINE_X && x < FINISH_LINE_X && y < 0, and armed
//     -> lap++ (saturating), clear armed. Crossing while unarmed: no count.
//   - Reverse crossing (prev_x < FL, x >= FL): no count, does not disarm.
//   - prev_x loaded on the first RACE tick before any crossing check (no lap on entry).
//   - Any car reaching LAP_MAX -> FINISH on the next tick edge; winner = that car;
//     both reaching it on the same tick -> winner=3.
//  FINISH: o_physics_en=0, laps/winner frozen. Hold counter counts FINISH_HOLD_FRAMES
//   ticks then -> IDLE (laps remain displayed until next INIT). i_start on a tick
//   in FINISH after >=1 hold tick -> INIT immediately (rematch).
//  Arithmetic: positions compared signed (POS_WIDTH); frame counters unsigned, width
//   $clog2 of their max; no wrap of any counter is ever reachable.
// STRUCTURE
//  game_pkg additions: typedef enum logic[2:0] RaceState {RACE_IDLE, RACE_INIT,
//   RACE_COUNTDOWN, RACE_RUN, RACE_FINISH}; FINISH_LINE_X (uncomment), CHECKPOINT_X,
//   COUNTDOWN_SEC, FRAMES_PER_SEC, FINISH_HOLD_FRAMES.
//  Sub-module lap_tracker (x2): prev_x reg, armed flag, saturating lap counter,
//   inputs clr/en/tick/x/y, output lap + reached_max. Top holds FSM + timers.
// TESTING
//  1 Reset mid-RACE with lap=2 -> same cycle o_state=IDLE, laps=0, physics_en=0.
//  2 i_start on tick in IDLE -> INIT, one o_load_init pulse, then countdown 3/2/1 for
//    60 ticks each, RACE on tick 180 with o_physics_en=1.
//  3 car1 x: -500 -> -540 at y=-300 without checkpoint -> lap stays 0; after x=520
//    then -500 -> -540 -> lap=1; crossing at y=+100 -> no count.
//  4 car1 completes 3 armed laps, car2 at 2 -> FINISH, o_winner=1, physics_en=0,
//    after 300 ticks -> IDLE with lap display 3/2 retained.
//  5 both cars cross third lap on same tick -> o_winner=3.
//  6 i_start in FINISH after 10 ticks -> INIT, laps/winner cleared, load_init pulse;
//    i_start during COUNTDOWN/RACE -> no effect.

Source files
------------

// File: rtl/race_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : race_sequencer_pkg
//  Description : Shared game-flow constants, race state encoding and a small
//                counter-width helper for the race sequencer slice.
//  Revision    : 1.0 - initial release
// ============================================================================
package race_sequencer_pkg;

    localparam int LAP_MAX            = 3;
    localparam int FRAMES_PER_SEC     = 60;
    localparam int COUNTDOWN_SEC      = 3;
    localparam int FINISH_HOLD_FRAMES = 300;
    localparam int POS_WIDTH          = 12;
    localparam int FINISH_LINE_X      = -538;
    localparam int CHECKPOINT_X       = 500;
    localparam int SINGLE_DIGIT_WIDTH = 4;

    typedef enum logic [2:0] {
        RACE_IDLE      = 3'd0,
        RACE_INIT      = 3'd1,
        RACE_COUNTDOWN = 3'd2,
        RACE_RUN       = 3'd3,
        RACE_FINISH    = 3'd4
    } race_state_t;

    // Width of a counter that only ever holds values 0..max_count-1.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/race_sequencer_lap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : race_sequencer_lap_tracker
//  Description : Per-car lap counter. Arms on reaching the checkpoint, counts
//                an armed forward crossing of the finish line on the lower
//                half of the track, saturates at LAP_MAX.
//  Revision    : 1.0 - initial release
// ============================================================================
module race_sequencer_lap_tracker #(
    parameter int LAP_MAX       = race_sequencer_pkg::LAP_MAX,
    parameter int POS_WIDTH     = race_sequencer_pkg::POS_WIDTH,
    parameter int FINISH_LINE_X = race_sequencer_pkg::FINISH_LINE_X,
    parameter int CHECKPOINT_X  = race_sequencer_pkg::CHECKPOINT_X
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_tick,
    input  logic                                             i_clr,
    input  logic                                             i_en,
    input  logic signed [POS_WIDTH-1:0]                      i_x,
    input  logic signed [POS_WIDTH-1:0]                      i_y,
    output logic [race_sequencer_pkg::SINGLE_DIGIT_WIDTH-1:0] o_lap,
    output logic                                             o_reached_max
);
    import race_sequencer_pkg::*;

    localparam logic signed [POS_WIDTH-1:0] c_finish_x     = POS_WIDTH'(FINISH_LINE_X);
    localparam logic signed [POS_WIDTH-1:0] c_checkpoint_x = POS_WIDTH'(CHECKPOINT_X);
    localparam logic [SINGLE_DIGIT_WIDTH-1:0] c_lap_max    = SINGLE_DIGIT_WIDTH'(LAP_MAX);

    logic signed [POS_WIDTH-1:0]   r_prev_x;
    logic                          r_prev_valid;
    logic                          r_armed;
    logic [SINGLE_DIGIT_WIDTH-1:0] r_lap;

    logic w_at_checkpoint;
    logic w_crossing;

    // The first enabled tick only captures prev_x, so a car parked across the
    // line at race start cannot score.
    assign w_at_checkpoint = (i_x >= c_checkpoint_x);
    assign w_crossing      = r_prev_valid && (r_prev_x >= c_finish_x) &&
                             (i_x < c_finish_x) && i_y[POS_WIDTH-1];

    // Previous-x capture, checkpoint arming and saturating lap count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev_x     <= '0;
            r_prev_valid <= 1'b0;
            r_armed      <= 1'b0;
            r_lap        <= '0;
        end else if (i_tick) begin
            if (i_clr) begin
                r_prev_x     <= '0;
                r_prev_valid <= 1'b0;
                r_armed      <= 1'b0;
                r_lap        <= '0;
            end else if (i_en) begin
                r_prev_x     <= i_x;
                r_prev_valid <= 1'b1;
                if (w_crossing && r_armed) begin
                    r_armed <= 1'b0;
                    if (r_lap != c_lap_max) begin
                        r_lap <= r_lap + 1'b1;
                    end
                end else if (w_at_checkpoint) begin
                    r_armed <= 1'b1;
                end
            end
        end
    end

    assign o_lap         = r_lap;
    assign o_reached_max = (r_lap == c_lap_max);

endmodule
`default_nettype wire

// File: rtl/race_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : race_sequencer
//  Description : Race game-flow controller: reload, 3-2-1 countdown, race with
//                per-car lap counting, winner declaration and result hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module race_sequencer #(
    parameter int LAP_MAX            = race_sequencer_pkg::LAP_MAX,
    parameter int FRAMES_PER_SEC     = race_sequencer_pkg::FRAMES_PER_SEC,
    parameter int COUNTDOWN_SEC      = race_sequencer_pkg::COUNTDOWN_SEC,
    parameter int FINISH_HOLD_FRAMES = race_sequencer_pkg::FINISH_HOLD_FRAMES,
    parameter int POS_WIDTH          = race_sequencer_pkg::POS_WIDTH,
    parameter int FINISH_LINE_X      = race_sequencer_pkg::FINISH_LINE_X,
    parameter int CHECKPOINT_X       = race_sequencer_pkg::CHECKPOINT_X
) (
    input  logic                                             i_clk,
    input  logic                                             i_rst,
    input  logic                                             i_frame_tick,
    input  logic                                             i_start,
    input  logic signed [POS_WIDTH-1:0]                      i_car1_x,
    input  logic signed [POS_WIDTH-1:0]                      i_car1_y,
    input  logic signed [POS_WIDTH-1:0]                      i_car2_x,
    input  logic signed [POS_WIDTH-1:0]                      i_car2_y,
    output logic [2:0]                                       o_state,
    output logic                                             o_load_init,
    output logic                                             o_physics_en,
    output logic [race_sequencer_pkg::SINGLE_DIGIT_WIDTH-1:0] o_countdown,
    output logic [race_sequencer_pkg::SINGLE_DIGIT_WIDTH-1:0] o_car1_lap,
    output logic [race_sequencer_pkg::SINGLE_DIGIT_WIDTH-1:0] o_car2_lap,
    output logic [1:0]                                       o_winner
);
    import race_sequencer_pkg::*;

    localparam int c_cd_w   = cnt_width(FRAMES_PER_SEC);
    localparam int c_hold_w = cnt_width(FINISH_HOLD_FRAMES);

    localparam logic [c_cd_w-1:0]             c_fps_last  = c_cd_w'(FRAMES_PER_SEC - 1);
    localparam logic [c_hold_w-1:0]           c_hold_last = c_hold_w'(FINISH_HOLD_FRAMES - 1);
    localparam logic [SINGLE_DIGIT_WIDTH-1:0] c_cd_start  = SINGLE_DIGIT_WIDTH'(COUNTDOWN_SEC);

    race_state_t                   r_state;
    race_state_t                   w_next_state;
    logic [c_cd_w-1:0]             r_cd_frames;
    logic [SINGLE_DIGIT_WIDTH-1:0] r_countdown;
    logic [c_hold_w-1:0]           r_hold;
    logic [1:0]                    r_winner;
    logic                          r_load_init;

    logic w_car1_max;
    logic w_car2_max;
    logic w_enter_init;
    logic w_track_en;
    logic w_cd_wrap;
    logic w_cd_last;
    logic w_hold_done;

    assign w_cd_wrap   = (r_cd_frames == c_fps_last);
    assign w_cd_last   = (r_countdown == SINGLE_DIGIT_WIDTH'(1));
    assign w_hold_done = (r_hold == c_hold_last);

    // Laps freeze as soon as either car has won so the result seen at the
    // FINISH edge is the one that gets displayed.
    assign w_track_en  = (r_state == RACE_RUN) && !w_car1_max && !w_car2_max;

    // Next-state decode; nothing moves except on a frame tick.
    always_comb begin
        w_next_state = r_state;
        if (i_frame_tick) begin
            case (r_state)
                RACE_IDLE: begin
                    if (i_start) w_next_state = RACE_INIT;
                end
                RACE_INIT: begin
                    w_next_state = RACE_COUNTDOWN;
                end
                RACE_COUNTDOWN: begin
                    if (w_cd_wrap && w_cd_last) w_next_state = RACE_RUN;
                end
                RACE_RUN: begin
                    if (w_car1_max || w_car2_max) w_next_state = RACE_FINISH;
                end
                RACE_FINISH: begin
                    if (i_start && (r_hold != '0)) w_next_state = RACE_INIT;
                    else if (w_hold_done)          w_next_state = RACE_IDLE;
                end
                default: begin
                    w_next_state = RACE_IDLE;
                end
            endcase
        end
    end

    assign w_enter_init = (w_next_state == RACE_INIT) && (r_state != RACE_INIT);

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= RACE_IDLE;
        else       r_state <= w_next_state;
    end

    // Countdown/hold timers, winner latch and the reload pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cd_frames <= '0;
            r_countdown <= '0;
            r_hold      <= '0;
            r_winner    <= '0;
            r_load_init <= 1'b0;
        end else begin
            r_load_init <= w_enter_init;
            if (i_frame_tick) begin
                case (r_state)
                    RACE_INIT: begin
                        r_countdown <= c_cd_start;
                        r_cd_frames <= '0;
                    end
                    RACE_COUNTDOWN: begin
                        if (w_cd_wrap) begin
                            r_cd_frames <= '0;
                            r_countdown <= r_countdown - 1'b1;
                        end else begin
                            r_cd_frames <= r_cd_frames + 1'b1;
                        end
                    end
                    RACE_RUN: begin
                        if (w_next_state == RACE_FINISH) begin
                            r_winner <= {w_car2_max, w_car1_max};
                            r_hold   <= '0;
                        end
                    end
                    RACE_FINISH: begin
                        if (!w_hold_done) r_hold <= r_hold + 1'b1;
                    end
                    default: begin
                    end
                endcase
                if (w_enter_init) r_winner <= '0;
            end
        end
    end

    race_sequencer_lap_tracker #(
        .LAP_MAX       (LAP_MAX),
        .POS_WIDTH     (POS_WIDTH),
        .FINISH_LINE_X (FINISH_LINE_X),
        .CHECKPOINT_X  (CHECKPOINT_X)
    ) u_car1_lap (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_tick        (i_frame_tick),
        .i_clr         (w_enter_init),
        .i_en          (w_track_en),
        .i_x           (i_car1_x),
        .i_y           (i_car1_y),
        .o_lap         (o_car1_lap),
        .o_reached_max (w_car1_max)
    );

    race_sequencer_lap_tracker #(
        .LAP_MAX       (LAP_MAX),
        .POS_WIDTH     (POS_WIDTH),
        .FINISH_LINE_X (FINISH_LINE_X),
        .CHECKPOINT_X  (CHECKPOINT_X)
    ) u_car2_lap (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_tick        (i_frame_tick),
        .i_clr         (w_enter_init),
        .i_en          (w_track_en),
        .i_x           (i_car2_x),
        .i_y           (i_car2_y),
        .o_lap         (o_car2_lap),
        .o_reached_max (w_car2_max)
    );

    assign o_state      = r_state;
    assign o_load_init  = r_load_init;
    assign o_physics_en = (r_state == RACE_RUN);
    assign o_countdown  = r_countdown;
    assign o_winner     = r_winner;

endmodule
`default_nettype wire

// File: tb/tb_race_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_race_sequencer
//  Description : Scoreboard bench for race_sequencer: full race flows, lap
//                arming rules, winner/tie, result hold, rematch and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_race_sequencer;

    localparam int ST_IDLE   = 0;
    localparam int ST_INIT   = 1;
    localparam int ST_CD     = 2;
    localparam int ST_RUN    = 3;
    localparam int ST_FINISH = 4;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_frame_tick;
    logic               i_start;
    logic signed [11:0] i_car1_x;
    logic signed [11:0] i_car1_y;
    logic signed [11:0] i_car2_x;
    logic signed [11:0] i_car2_y;
    logic [2:0]         o_state;
    logic               o_load_init;
    logic               o_physics_en;
    logic [3:0]         o_countdown;
    logic [3:0]         o_car1_lap;
    logic [3:0]         o_car2_lap;
    logic [1:0]         o_winner;

    race_sequencer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_frame_tick (i_frame_tick),
        .i_start      (i_start),
        .i_car1_x     (i_car1_x),
        .i_car1_y     (i_car1_y),
        .i_car2_x     (i_car2_x),
        .i_car2_y     (i_car2_y),
        .o_state      (o_state),
        .o_load_init  (o_load_init),
        .o_physics_en (o_physics_en),
        .o_countdown  (o_countdown),
        .o_car1_lap   (o_car1_lap),
        .o_car2_lap   (o_car2_lap),
        .o_winner     (o_winner)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        string tag;
        int    st;
        int    l1;
        int    l2;
        int    cd;
        int    win;
        int    phys;
        int    ld;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fails  = 0;

    int e_st, e_l1, e_l2, e_cd, e_win, e_phys, e_ld;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic compare_out();
        exp_t e;
        e = sb_q.pop_front();
        check_val({e.tag, ".state"},  32'(o_state),      32'(e.st));
        check_val({e.tag, ".lap1"},   32'(o_car1_lap),   32'(e.l1));
        check_val({e.tag, ".lap2"},   32'(o_car2_lap),   32'(e.l2));
        check_val({e.tag, ".cd"},     32'(o_countdown),  32'(e.cd));
        check_val({e.tag, ".phys"},   32'(o_physics_en), 32'(e.phys));
        check_val({e.tag, ".load"},   32'(o_load_init),  32'(e.ld));
        if (e.st != ST_IDLE)
            check_val({e.tag, ".win"}, 32'(o_winner),    32'(e.win));
    endtask

    // One quiet cycle (regs must hold), then one frame tick, then compare.
    task automatic tick_check(input string tag);
        exp_t e;
        e.tag = tag; e.st = e_st; e.l1 = e_l1; e.l2 = e_l2;
        e.cd = e_cd; e.win = e_win; e.phys = e_phys; e.ld = e_ld;
        sb_q.push_back(e);
        @(posedge i_clk); #1;
        i_frame_tick = 1'b1;
        @(posedge i_clk); #1;
        i_frame_tick = 1'b0;
        compare_out();
    endtask

    task automatic set_pos(input int x1, input int y1, input int x2, input int y2);
        i_car1_x = 12'(x1); i_car1_y = 12'(y1);
        i_car2_x = 12'(x2); i_car2_y = 12'(y2);
    endtask

    task automatic step1(input int x1, input int y1, input string tag);
        i_car1_x = 12'(x1); i_car1_y = 12'(y1);
        tick_check(tag);
    endtask

    task automatic start_race(input logic hold_start, input string tag);
        i_start = 1'b1;
        e_st = ST_INIT; e_ld = 1; e_l1 = 0; e_l2 = 0; e_win = 0; e_phys = 0;
        tick_check({tag, ".init"});
        e_ld = 0;
        i_start = hold_start;
        e_st = ST_CD; e_cd = 3;
        tick_check({tag, ".cd_entry"});
        for (int k = 1; k <= 180; k++) begin
            e_st   = (k == 180) ? ST_RUN : ST_CD;
            e_cd   = (k == 180) ? 0 : 3 - k / 60;
            e_phys = (k == 180) ? 1 : 0;
            tick_check($sformatf("%s.cd%0d", tag, k));
        end
    endtask

    // Checkpoint, approach, then cross on the lower half for the selected cars.
    task automatic do_lap(input logic c1, input logic c2, input string tag);
        int xs[3];
        xs = '{520, -500, -540};
        for (int i = 0; i < 3; i++) begin
            if (c1) begin i_car1_x = 12'(xs[i]); i_car1_y = -12'sd300; end
            if (c2) begin i_car2_x = 12'(xs[i]); i_car2_y = -12'sd300; end
            if (i == 2) begin
                e_l1 = e_l1 + (c1 ? 1 : 0);
                e_l2 = e_l2 + (c2 ? 1 : 0);
            end
            tick_check($sformatf("%s.p%0d", tag, i));
        end
    endtask

    initial begin
        i_rst = 1'b1; i_frame_tick = 1'b0; i_start = 1'b0;
        set_pos(-500, -300, 0, 100);
        repeat (3) @(posedge i_clk);
        #1;
        check_val("rst.state", 32'(o_state),      32'(ST_IDLE));
        check_val("rst.lap1",  32'(o_car1_lap),   0);
        check_val("rst.cd",    32'(o_countdown),  0);
        check_val("rst.phys",  32'(o_physics_en), 0);
        check_val("rst.win",   32'(o_winner),     0);
        i_rst = 1'b0;
        e_st = ST_IDLE; e_l1 = 0; e_l2 = 0; e_cd = 0; e_win = 0; e_phys = 0; e_ld = 0;

        tick_check("idle_nostart");

        // Countdown then lap arming rules on car1.
        start_race(1'b0, "r1");
        step1(-500, -300, "s3.entry");
        step1(-540, -300, "s3.unarmed");
        step1( 520, -300, "s3.arm");
        step1(-500, -300, "s3.pre");
        e_l1 = 1;
        step1(-540, -300, "s3.lap1");
        step1( 520, -300, "s3.arm2");
        step1(-500,  100, "s3.pre_top");
        step1(-540,  100, "s3.ypos");
        step1(-500, -300, "s3.reverse");
        e_l1 = 2;
        step1(-540, -300, "s3.lap2");

        // Asynchronous reset mid-race.
        i_rst = 1'b1;
        #2;
        check_val("arst.state", 32'(o_state),      32'(ST_IDLE));
        check_val("arst.lap1",  32'(o_car1_lap),   0);
        check_val("arst.phys",  32'(o_physics_en), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        e_st = ST_IDLE; e_l1 = 0; e_l2 = 0; e_cd = 0; e_win = 0; e_phys = 0; e_ld = 0;

        // Car1 wins 3-2, result held, auto-return to IDLE.
        set_pos(-500, -300, 0, 100);
        start_race(1'b0, "r2");
        step1(-500, -300, "r2.entry");
        do_lap(1'b1, 1'b1, "r2.lapA");
        do_lap(1'b1, 1'b1, "r2.lapB");
        do_lap(1'b1, 1'b0, "r2.lapC");
        e_st = ST_FINISH; e_win = 1; e_phys = 0;
        tick_check("r2.finish");
        for (int k = 1; k <= 300; k++) begin
            e_st = (k == 300) ? ST_IDLE : ST_FINISH;
            tick_check($sformatf("r2.hold%0d", k));
        end

        // Tie with i_start held through countdown and race, then rematch.
        start_race(1'b1, "r3");
        tick_check("r3.entry");
        do_lap(1'b1, 1'b1, "r3.lapA");
        do_lap(1'b1, 1'b1, "r3.lapB");
        do_lap(1'b1, 1'b1, "r3.lapC");
        e_st = ST_FINISH; e_win = 3; e_phys = 0;
        tick_check("r3.finish");
        tick_check("r3.hold1_start");
        i_start = 1'b0;
        for (int k = 2; k <= 10; k++) tick_check($sformatf("r3.hold%0d", k));
        i_start = 1'b1;
        e_st = ST_INIT; e_ld = 1; e_l1 = 0; e_l2 = 0; e_win = 0;
        tick_check("r3.rematch");
        i_start = 1'b0;
        e_ld = 0; e_st = ST_CD; e_cd = 3;
        tick_check("r3.rematch_cd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
